// File: rtl/nios_system_pio_pkg.sv
// Shared definitions for the Nios II system PIO blocks.
// Contents: Avalon register offsets and edge-capture mode encodings.
package nios_system_pio_pkg;

    // Avalon word offsets of the PIO register map
    localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
    localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

    // Edge-capture modes selected by the EDGE_TYPE parameter
    localparam int EDGE_RISING  = 32'sd0;
    localparam int EDGE_FALLING = 32'sd1;
    localparam int EDGE_ANY     = 32'sd2;

endpackage

// File: rtl/nios_system_key_debounce.sv
// Single-bit input conditioner for a board key or switch.
// A two-flop synchronizer feeds a stability counter; the debounced level
// only follows the synchronized input after it has differed for
// DEBOUNCE_CYCLES consecutive clocks.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset (all state returns to IDLE_BIT)
//   in_bit   raw asynchronous input
//   stable   debounced level
module nios_system_key_debounce #(
    parameter int   DEBOUNCE_CYCLES = 500000,
    parameter logic IDLE_BIT        = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_bit,
    output logic stable
);

    localparam int               CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_r;
    logic             sync_r;
    logic             stable_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchronizer, stability counter and debounced level register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_r   <= IDLE_BIT;
            sync_r   <= IDLE_BIT;
            stable_r <= IDLE_BIT;
            cnt_r    <= {CNT_W{1'b0}};
        end else begin
            meta_r <= in_bit;
            sync_r <= meta_r;
            if (sync_r == stable_r) begin
                // Any return to the accepted level restarts the qualification
                cnt_r <= {CNT_W{1'b0}};
            end else if (cnt_r == LAST) begin
                stable_r <= sync_r;
                cnt_r    <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign stable = stable_r;

endmodule

// File: rtl/nios_system_key_pio.sv
// Avalon-MM input PIO for push-buttons and switches.
// Each input bit is synchronized and debounced; qualifying edges of the
// debounced level set sticky EDGECAP bits (write-1-to-clear), and irq is
// raised while any captured edge is enabled in IRQMASK.
// Ports:
//   clk, reset_n          system clock, asynchronous active-low reset
//   address               word offset (0 DATA, 2 IRQMASK, 3 EDGECAP)
//   chipselect, write_n   slave select and active-low write strobe
//   writedata             write data
//   in_port               raw asynchronous board inputs
//   readdata              combinational read data, zero wait states
//   irq                   active-high level interrupt
module nios_system_key_pio
    import nios_system_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int EDGE_TYPE       = 1,
    parameter int IDLE_LEVEL      = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic             IDLE_BIT = (IDLE_LEVEL != 0) ? 1'b1 : 1'b0;
    localparam logic [WIDTH-1:0] IDLE_VEC = {WIDTH{IDLE_BIT}};

    logic [WIDTH-1:0] stable_s;
    logic [WIDTH-1:0] stable_d_r;
    logic [WIDTH-1:0] edge_s;
    logic [WIDTH-1:0] clr_s;
    logic [WIDTH-1:0] edgecap_r;
    logic [WIDTH-1:0] irqmask_r;
    logic             wr_s;
    logic             unused_s;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        nios_system_key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .IDLE_BIT        (IDLE_BIT)
        ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .in_bit  (in_port[i]),
            .stable  (stable_s[i])
        );
    end

    assign wr_s = chipselect & ~write_n;

    // Only the low WIDTH bits of writedata are stored
    assign unused_s = ^writedata;

    // Edge qualification of the debounced level
    always_comb begin
        edge_s = {WIDTH{1'b0}};
        case (EDGE_TYPE)
            EDGE_RISING:  edge_s = stable_s & ~stable_d_r;
            EDGE_FALLING: edge_s = ~stable_s & stable_d_r;
            EDGE_ANY:     edge_s = stable_s ^ stable_d_r;
            default:      edge_s = stable_s ^ stable_d_r;
        endcase
    end

    // Write-1-to-clear mask for EDGECAP
    always_comb begin
        clr_s = {WIDTH{1'b0}};
        if (wr_s && (address == PIO_ADDR_EDGECAP)) begin
            clr_s = writedata[WIDTH-1:0];
        end else begin
            clr_s = {WIDTH{1'b0}};
        end
    end

    // Delayed level, sticky edge capture and interrupt mask registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_d_r <= IDLE_VEC;
            edgecap_r  <= {WIDTH{1'b0}};
            irqmask_r  <= {WIDTH{1'b0}};
        end else begin
            stable_d_r <= stable_s;
            // A new edge outranks a simultaneous clear of the same bit
            edgecap_r  <= (edgecap_r & ~clr_s) | edge_s;
            if (wr_s && (address == PIO_ADDR_IRQMASK)) begin
                irqmask_r <= writedata[WIDTH-1:0];
            end
        end
    end

    // Read mux; unused offsets and bits above WIDTH read zero
    always_comb begin
        readdata = 32'd0;
        case (address)
            PIO_ADDR_DATA:    readdata[WIDTH-1:0] = stable_s;
            PIO_ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask_r;
            PIO_ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap_r;
            default:          readdata = 32'd0;
        endcase
    end

    assign irq = |(edgecap_r & irqmask_r);

endmodule

// File: tb/tb_nios_system_key_pio.sv
// Self-checking bench for nios_system_key_pio (WIDTH=4, DEBOUNCE_CYCLES=4,
// falling-edge capture, idle level 1). Directed table, hand sequences for
// glitch / collision / mask / mid-debounce reset, then random traffic
// checked against a behavioural model.
module tb_nios_system_key_pio;

    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [3:0]  in_port = 4'hF;
    logic [31:0] readdata;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    nios_system_key_pio #(
        .WIDTH(4), .DEBOUNCE_CYCLES(DB), .EDGE_TYPE(1), .IDLE_LEVEL(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .in_port(in_port), .readdata(readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    // Behavioural model: input delay line, window of synchronized samples
    logic [3:0] m_d1, m_d2, m_stable, m_prev, m_ecap, m_mask;
    logic [3:0] m_win[$];

    task automatic model_reset();
        m_d1 = 4'hF; m_d2 = 4'hF; m_stable = 4'hF; m_prev = 4'hF;
        m_ecap = 4'h0; m_mask = 4'h0;
        m_win.delete();
    endtask

    task automatic model_step();
        logic [3:0] sync_pre, nxt, clr, edges;
        logic       wr;
        bit         all_diff;
        sync_pre = m_d2;
        m_d2 = m_d1;
        m_d1 = in_port;
        m_win.push_back(sync_pre);
        if (m_win.size() > DB) void'(m_win.pop_front());
        edges = ~m_stable & m_prev;
        nxt = m_stable;
        // A bit flips once DB consecutive synchronized samples disagree with it
        for (int b = 0; b < 4; b++) begin
            all_diff = (m_win.size() == DB);
            foreach (m_win[i]) if (m_win[i][b] == m_stable[b]) all_diff = 1'b0;
            if (all_diff) nxt[b] = ~m_stable[b];
        end
        wr  = chipselect && !write_n;
        clr = (wr && address == 2'd3) ? writedata[3:0] : 4'h0;
        m_ecap = (m_ecap & ~clr) | edges;
        if (wr && address == 2'd2) m_mask = writedata[3:0];
        m_prev = m_stable;
        m_stable = nxt;
    endtask

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_stable};
            2'd2:    return {28'd0, m_mask};
            2'd3:    return {28'd0, m_ecap};
            default: return 32'd0;
        endcase
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] in, input logic we, input logic [1:0] a,
                         input logic [31:0] wd);
        in_port    = in;
        chipselect = 1'b1;
        write_n    = ~we;
        address    = a;
        writedata  = wd;
    endtask

    task automatic clk1();
        @(posedge clk);
        if (reset_n) model_step();
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] exp_rd, input logic exp_irq);
        #1;
        cmp({name, "_rd"}, readdata, exp_rd);
        cmp({name, "_irq"}, {31'd0, irq}, {31'd0, exp_irq});
    endtask

    task automatic chk_model(input string name);
        #1;
        cmp({name, "_rd"}, readdata, m_read(address));
        cmp({name, "_irq"}, {31'd0, irq}, {31'd0, |(m_ecap & m_mask)});
    endtask

    task automatic do_reset(input logic [3:0] in);
        #1;
        reset_n = 1'b0;
        drive(in, 1'b0, 2'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [3:0]  in;
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t tbl[20];
    logic [3:0] cur_in;

    initial begin
        // in, we, addr, wdata, expected readdata (before this edge), expected irq
        tbl[0]  = '{4'hF, 1'b0, 2'd0, 32'd0,      32'hF, 1'b0};
        tbl[1]  = '{4'hF, 1'b0, 2'd2, 32'd0,      32'h0, 1'b0};
        tbl[2]  = '{4'hF, 1'b0, 2'd3, 32'd0,      32'h0, 1'b0};
        tbl[3]  = '{4'hF, 1'b0, 2'd1, 32'd0,      32'h0, 1'b0};
        tbl[4]  = '{4'hF, 1'b1, 2'd2, 32'd1,      32'h0, 1'b0};
        tbl[5]  = '{4'hE, 1'b0, 2'd0, 32'd0,      32'hF, 1'b0};
        tbl[6]  = '{4'hE, 1'b0, 2'd0, 32'd0,      32'hF, 1'b0};
        tbl[7]  = '{4'hE, 1'b0, 2'd0, 32'd0,      32'hF, 1'b0};
        tbl[8]  = '{4'hE, 1'b0, 2'd0, 32'd0,      32'hF, 1'b0};
        tbl[9]  = '{4'hE, 1'b0, 2'd0, 32'd0,      32'hF, 1'b0};
        tbl[10] = '{4'hE, 1'b0, 2'd0, 32'd0,      32'hF, 1'b0};
        tbl[11] = '{4'hE, 1'b0, 2'd0, 32'd0,      32'hE, 1'b0};
        tbl[12] = '{4'hE, 1'b0, 2'd3, 32'd0,      32'h1, 1'b1};
        tbl[13] = '{4'hE, 1'b1, 2'd3, 32'd1,      32'h1, 1'b1};
        tbl[14] = '{4'hE, 1'b0, 2'd3, 32'd0,      32'h0, 1'b0};
        tbl[15] = '{4'hE, 1'b0, 2'd2, 32'd0,      32'h1, 1'b0};
        tbl[16] = '{4'hE, 1'b1, 2'd1, 32'hFFFF,   32'h0, 1'b0};
        tbl[17] = '{4'hE, 1'b1, 2'd0, 32'h0,      32'hE, 1'b0};
        tbl[18] = '{4'hE, 1'b0, 2'd0, 32'd0,      32'hE, 1'b0};
        tbl[19] = '{4'hE, 1'b0, 2'd1, 32'd0,      32'h0, 1'b0};

        // Directed table: reset state, debounce latency, capture, W1C
        do_reset(4'hF);
        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].in, tbl[i].we, tbl[i].addr, tbl[i].wd);
            chk($sformatf("vec%0d", i), tbl[i].exp_rd, tbl[i].exp_irq);
            clk1();
        end

        // Glitches of 3 cycles on bit 1 never pass the debouncer
        do_reset(4'hF);
        for (int r = 0; r < 5; r++) begin
            repeat (3) begin drive(4'hD, 1'b0, 2'd0, 32'd0); chk("glitch_lo", 32'hF, 1'b0); clk1(); end
            repeat (3) begin drive(4'hF, 1'b0, 2'd0, 32'd0); chk("glitch_hi", 32'hF, 1'b0); clk1(); end
        end
        drive(4'hF, 1'b0, 2'd3, 32'd0);
        chk("glitch_ecap", 32'h0, 1'b0);

        // Edge capture on bit 2 coinciding with a W1C of bit 2: set wins
        do_reset(4'hF);
        for (int k = 0; k < 6; k++) begin
            drive(4'hB, 1'b0, 2'd3, 32'd0); chk("coll_pre", 32'h0, 1'b0); clk1();
        end
        drive(4'hB, 1'b1, 2'd3, 32'h4);
        chk("coll_wr", 32'h0, 1'b0);
        clk1();
        drive(4'hB, 1'b0, 2'd3, 32'd0);
        chk("coll_ecap", 32'h4, 1'b0);
        drive(4'hB, 1'b0, 2'd0, 32'd0);
        chk("coll_data", 32'hB, 1'b0);

        // Masked capture, later unmasked; rising edge captures nothing
        do_reset(4'hF);
        repeat (7) begin drive(4'h7, 1'b0, 2'd0, 32'd0); clk1(); end
        drive(4'h7, 1'b0, 2'd3, 32'd0);
        chk("mask_ecap", 32'h8, 1'b0);
        drive(4'h7, 1'b1, 2'd2, 32'h8);
        chk("mask_wr", 32'h0, 1'b0);
        clk1();
        drive(4'h7, 1'b0, 2'd2, 32'd0);
        chk("mask_on", 32'h8, 1'b1);
        repeat (8) begin drive(4'hF, 1'b0, 2'd3, 32'd0); chk("mask_rise", 32'h8, 1'b1); clk1(); end
        drive(4'hF, 1'b0, 2'd0, 32'd0);
        chk("mask_data", 32'hF, 1'b1);

        // Reset mid-debounce discards the partial count
        do_reset(4'hF);
        repeat (5) begin drive(4'hE, 1'b0, 2'd0, 32'd0); chk("mid_pre", 32'hF, 1'b0); clk1(); end
        do_reset(4'hE);
        for (int k = 0; k < 8; k++) begin
            drive(4'hE, 1'b0, 2'd0, 32'd0);
            chk($sformatf("mid_data%0d", k), (k >= 6) ? 32'hE : 32'hF, 1'b0);
            clk1();
        end
        drive(4'hE, 1'b0, 2'd3, 32'd0);
        chk("mid_ecap", 32'h1, 1'b0);

        // Random traffic against the model
        do_reset(4'hF);
        cur_in = 4'hF;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 5) == 0) cur_in = 4'($urandom);
            in_port    = cur_in;
            chipselect = ($urandom_range(0, 3) != 0);
            write_n    = ($urandom_range(0, 5) != 0);
            address    = 2'($urandom);
            writedata  = $urandom;
            chk_model("rand");
            clk1();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
